alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 21 ++
 rtl/alu_arbiter_alu.sv | 37 +++
 rtl/alu_arbiter.sv | 116 +++++++++++
 tb/tb_alu_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared ALU definitions: datapath width, opcode encodings and slot FSM states.
// Imported by the shared ALU and by the two-requester arbiter around it.
package alu_arbiter_pkg;
    localparam int W = 64;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: op_legal = 1'b1;
            default:                                       op_legal = 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 64-bit ALU: op[3] inverts A, op[2] negates B (invert plus carry-in),
// op[1:0] selects AND/OR/ADD/SLT. Overflow is reported for the adder path only.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [3:0]   op,
    output logic [W-1:0] result,
    output logic         ovf,
    output logic         zero
);
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic [W:0]   sum;
    logic         add_ovf;

    always_comb begin
        a_in    = op[3] ? ~a : a;
        b_in    = op[2] ? ~b : b;
        sum     = {1'b0, a_in} + {1'b0, b_in} + {{W{1'b0}}, op[2]};
        // carry into the MSB recovered from the MSB sum bit, compared with carry-out
        add_ovf = (a_in[W-1] ^ b_in[W-1] ^ sum[W-1]) ^ sum[W];
        result  = '0;
        ovf     = 1'b0;
        case (op[1:0])
            2'b00: result = a_in & b_in;
            2'b01: result = a_in | b_in;
            2'b10: begin
                result = sum[W-1:0];
                ovf    = add_ovf;
            end
            default: result = {{(W-1){1'b0}}, sum[W-1] ^ add_ovf};
        endcase
        zero = (result == '0);
    end
endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU through a round-robin grant and a one-entry result slot.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter bit CHECK_OP = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [3:0]   req0_op,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [3:0]   req1_op,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [W-1:0] rsp_result,
    output logic         rsp_ovf,
    output logic         rsp_zero,
    output logic         rsp_err,
    output slot_state_t  dbg_state
);
    slot_state_t  state, state_n;
    logic         owner, owner_n;
    logic         ptr, ptr_n;
    logic [W-1:0] res_q, res_n;
    logic         ovf_q, ovf_n, zero_q, zero_n, err_q, err_n;

    logic         grant0, grant1, owner_done, slot_free, accept, sel, legal;
    logic [W-1:0] alu_a, alu_b, alu_res;
    logic [3:0]   alu_op;
    logic         alu_ovf, alu_zero;

    alu_arbiter_alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_res),
        .ovf    (alu_ovf),
        .zero   (alu_zero)
    );

    always_comb begin
        grant0     = req0_valid && (!req1_valid || !ptr);
        grant1     = req1_valid && (!req0_valid || ptr);
        owner_done = (state == FULL) && (owner ? rsp1_ready : rsp0_ready);
        slot_free  = (state == EMPTY) || owner_done;
        req0_ready = rst_n && slot_free && grant0;
        req1_ready = rst_n && slot_free && grant1;
        accept     = req0_ready || req1_ready;
        sel        = grant1;
        alu_a      = sel ? req1_a  : req0_a;
        alu_b      = sel ? req1_b  : req0_b;
        alu_op     = sel ? req1_op : req0_op;
        legal      = !CHECK_OP || op_legal(alu_op);

        state_n = state;
        owner_n = owner;
        ptr_n   = ptr;
        res_n   = res_q;
        ovf_n   = ovf_q;
        zero_n  = zero_q;
        err_n   = err_q;
        if (accept) begin
            state_n = FULL;
            owner_n = sel;
            ptr_n   = !sel;
            // an illegal opcode is answered with a zeroed result and only the error flag
            res_n   = legal ? alu_res : '0;
            ovf_n   = legal && alu_ovf;
            zero_n  = legal && alu_zero;
            err_n   = !legal;
        end else if (owner_done) begin
            state_n = EMPTY;
            res_n   = '0;
            ovf_n   = 1'b0;
            zero_n  = 1'b0;
            err_n   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            owner  <= 1'b0;
            ptr    <= 1'b0;
            res_q  <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_n;
            owner  <= owner_n;
            ptr    <= ptr_n;
            res_q  <= res_n;
            ovf_q  <= ovf_n;
            zero_q <= zero_n;
            err_q  <= err_n;
        end
    end

    assign rsp0_valid = (state == FULL) && !owner;
    assign rsp1_valid = (state == FULL) && owner;
    assign rsp_result = res_q;
    assign rsp_ovf    = ovf_q;
    assign rsp_zero   = zero_q;
    assign rsp_err    = err_q;
    assign dbg_state  = state;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized bench for alu_arbiter, checked each cycle against a
// queue-based reference of the arbiter and an arithmetic model of the ALU.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    typedef struct packed {
        logic [63:0] res;
        logic        ovf;
        logic        zero;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [63:0] rsp_result;
    logic        rsp_ovf, rsp_zero, rsp_err;
    slot_state_t dbg_state;

    int   checks = 0;
    int   errors = 0;
    rsp_t exp_q[$];
    bit   m_owner, m_ptr;
    int   last_grant;

    always #5 clk = ~clk;

    alu_arbiter #(.CHECK_OP(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_ovf(rsp_ovf), .rsp_zero(rsp_zero),
        .rsp_err(rsp_err), .dbg_state(dbg_state)
    );

    function automatic rsp_t ref_alu(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op);
        rsp_t r;
        r = '0;
        case (op)
            4'b0000: r.res = a & b;
            4'b0001: r.res = a | b;
            4'b0010: begin
                r.res = a + b;
                r.ovf = (a[63] == b[63]) && (r.res[63] != a[63]);
            end
            4'b0110: begin
                r.res = a - b;
                r.ovf = (a[63] != b[63]) && (r.res[63] != a[63]);
            end
            4'b0111: r.res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'b1100: r.res = ~(a | b);
            default: r.err = 1'b1;
        endcase
        r.zero = !r.err && (r.res == 64'd0);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic cycle();
        rsp_t r;
        bit   full, free, g, acc0, acc1;
        #1;
        full = (exp_q.size() != 0);
        r    = full ? exp_q[0] : '0;
        chk("rsp0_valid", rsp0_valid, full && !m_owner);
        chk("rsp1_valid", rsp1_valid, full && m_owner);
        chk("rsp_result", rsp_result, r.res);
        chk("rsp_ovf", rsp_ovf, r.ovf);
        chk("rsp_zero", rsp_zero, r.zero);
        chk("rsp_err", rsp_err, r.err);
        free = !full || (m_owner ? rsp1_ready : rsp0_ready);
        g    = (req0_valid && req1_valid) ? m_ptr : req1_valid;
        acc0 = rst_n && free && req0_valid && !g;
        acc1 = rst_n && free && req1_valid && g;
        chk("req0_ready", req0_ready, acc0);
        chk("req1_ready", req1_ready, acc1);
        last_grant = acc0 ? 0 : (acc1 ? 1 : -1);
        @(posedge clk);
        if (rst_n) begin
            if (full && free) void'(exp_q.pop_front());
            if (acc0 || acc1) begin
                exp_q.push_back(g ? ref_alu(req1_a, req1_b, req1_op) : ref_alu(req0_a, req0_b, req0_op));
                m_owner = g;
                m_ptr   = !g;
            end
        end
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_owner = 1'b0;
        m_ptr   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        cycle();
        cycle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    function automatic logic [63:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    logic [3:0] ops [6];
    int         exp_g [4];

    initial begin
        ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR};
        exp_g = '{0, 1, 0, 1};
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = OP_AND;
        req1_a = '0; req1_b = '0; req1_op = OP_AND;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        // ADD 5 + 7 from requester 0
        req0_valid = 1'b1; req0_a = 64'd5; req0_b = 64'd7; req0_op = OP_ADD;
        cycle();
        chk("add_valid", rsp0_valid, 1'b1);
        chk("add_result", rsp_result, 64'd12);
        chk("add_flags", {rsp_zero, rsp_ovf, rsp_err}, 3'b000);

        // SUB most-negative minus one overflows; accepted as the ADD drains
        req0_a = 64'h8000_0000_0000_0000; req0_b = 64'd1; req0_op = OP_SUB;
        cycle();
        chk("sub_result", rsp_result, 64'h7FFF_FFFF_FFFF_FFFF);
        chk("sub_ovf", rsp_ovf, 1'b1);
        req0_valid = 1'b0;
        cycle();

        // Alternating grants after reset with both requesters always valid
        do_reset();
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req0_a = {$urandom(), $urandom()}; req0_b = {$urandom(), $urandom()}; req0_op = OP_ADD;
            req1_a = {$urandom(), $urandom()}; req1_b = {$urandom(), $urandom()}; req1_op = OP_SUB;
            cycle();
            chk("rr_grant", last_grant, exp_g[i]);
        end

        // Requester 1 owns the slot and stalls its response for three cycles
        rsp1_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_rsp1_valid", rsp1_valid, 1'b1);
            chk("stall_no_grant", last_grant, -1);
        end
        rsp1_ready = 1'b1;
        cycle();
        chk("stall_release_grant", last_grant, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        cycle();

        // Illegal opcode, then SLT -1 < 0, both from requester 1
        req1_valid = 1'b1; req1_a = 64'd9; req1_b = 64'd3; req1_op = 4'b0011;
        cycle();
        chk("illegal_err", rsp_err, 1'b1);
        chk("illegal_result", rsp_result, 64'd0);
        req1_a = 64'hFFFF_FFFF_FFFF_FFFF; req1_b = 64'd0; req1_op = OP_SLT;
        cycle();
        chk("slt_result", rsp_result, 64'd1);
        chk("slt_err", rsp_err, 1'b0);
        chk("slt_ovf", rsp_ovf, 1'b0);
        req1_valid = 1'b0;
        cycle();

        // Reset while requester 0 holds an unconsumed result
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 64'd1; req0_b = 64'd1; req0_op = OP_OR;
        cycle();
        chk("pre_reset_valid", rsp0_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_drop_valid", rsp0_valid, 1'b0);
        chk("async_ready_low", req0_ready, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rsp0_ready = 1'b1;
        req1_valid = 1'b1; req1_op = OP_AND;
        cycle();
        chk("post_reset_grant", last_grant, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        cycle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
            req0_a = rand_operand(); req0_b = rand_operand();
            req1_a = rand_operand(); req1_b = rand_operand();
            req0_op = ($urandom_range(0, 7) < 6) ? ops[$urandom_range(0, 5)] : 4'($urandom_range(0, 15));
            req1_op = ($urandom_range(0, 7) < 6) ? ops[$urandom_range(0, 5)] : 4'($urandom_range(0, 15));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
